csr_file: RTL and testbench

Machine-mode CSR register file for the pipelined RV32I core with exception/interrupt support. It sits downstream of the interrupt/exception controller (CLINT) and alongside the execute stage. It accepts CSR-instruction reads and writes from EX and trap-sequence writes from the CLINT. It continuously drives `mtvec`, `mepc` and `mstatus` back to the CLINT and maintains the free-running `mcycle` and `minstret` counters.

---
 rtl/csr_file_pkg.sv | 96 +++++++++
 rtl/csr_counter64.sv | 43 ++++
 rtl/csr_file.sv | 181 ++++++++++++++++++
 tb/tb_csr_file.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_file_pkg
// Purpose  : Shared definitions for the machine-mode CSR file. This package
//            holds the CSR addresses, the mstatus write mask and reset value,
//            and an internal selector enum. It also provides decode and
//            write-legalisation helpers that the top level uses on both of
//            its write ports.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package csr_file_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // Only MIE[3] and MPIE[7] are writable in mstatus.
  // MPP[12:11] always reads as machine mode.
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
  localparam int          MSTATUS_MIE   = 3;

  // Internal register selector. Its encoding indexes the write-enable
  // one-hot vectors in the top level, so it must stay within 4 bits.
  typedef enum logic [3:0] {
    SEL_NONE      = 4'd0,
    SEL_MSTATUS   = 4'd1,
    SEL_MIE       = 4'd2,
    SEL_MTVEC     = 4'd3,
    SEL_MSCRATCH  = 4'd4,
    SEL_MEPC      = 4'd5,
    SEL_MCAUSE    = 4'd6,
    SEL_MIP       = 4'd7,
    SEL_MCYCLE    = 4'd8,
    SEL_MCYCLEH   = 4'd9,
    SEL_MINSTRET  = 4'd10,
    SEL_MINSTRETH = 4'd11,
    SEL_MHARTID   = 4'd12
  } csr_sel_e;

  function automatic csr_sel_e csr_decode(input logic [11:0] addr);
    csr_sel_e sel;
    case (addr)
      CSR_MSTATUS:   sel = SEL_MSTATUS;
      CSR_MIE:       sel = SEL_MIE;
      CSR_MTVEC:     sel = SEL_MTVEC;
      CSR_MSCRATCH:  sel = SEL_MSCRATCH;
      CSR_MEPC:      sel = SEL_MEPC;
      CSR_MCAUSE:    sel = SEL_MCAUSE;
      CSR_MIP:       sel = SEL_MIP;
      CSR_MCYCLE:    sel = SEL_MCYCLE;
      CSR_MCYCLEH:   sel = SEL_MCYCLEH;
      CSR_MINSTRET:  sel = SEL_MINSTRET;
      CSR_MINSTRETH: sel = SEL_MINSTRETH;
      CSR_MHARTID:   sel = SEL_MHARTID;
      default:       sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // Value a register holds after being written with raw data. For read-only
  // or unimplemented CSRs this is 0. The read path uses this result directly
  // when it forwards a same-cycle write.
  function automatic logic [31:0] csr_legalize(input csr_sel_e sel,
                                               input logic [31:0] data);
    logic [31:0] val;
    case (sel)
      SEL_MSTATUS:   val = (data & MSTATUS_WMASK) | MSTATUS_FIXED;
      SEL_MTVEC,
      SEL_MEPC:      val = {data[31:2], 2'b00};
      SEL_MIE,
      SEL_MSCRATCH,
      SEL_MCAUSE,
      SEL_MCYCLE,
      SEL_MCYCLEH,
      SEL_MINSTRET,
      SEL_MINSTRETH: val = data;
      default:       val = 32'h0;
    endcase
    return val;
  endfunction

endpackage : csr_file_pkg
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
// Module   : csr_counter64
// Purpose  : 64-bit free-running counter with an increment enable and
//            independent low and high write ports. Any write takes
//            precedence over the increment for that cycle. A half that is
//            not written keeps its value, and no carry is propagated into it.
// Ports    : clk, rst_n (sync, active-low)
//            inc                 - increment by one this cycle
//            we_lo / wdata_lo    - replace bits [31:0]
//            we_hi / wdata_hi    - replace bits [63:32]
//            value               - current counter value
// Revision : 1.0 - initial release
// ============================================================================
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        we_lo,
  input  logic [31:0] wdata_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata_hi,
  output logic [63:0] value
);

  logic [63:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 64'h0;
    end else if (we_lo || we_hi) begin
      if (we_lo) r_count[31:0]  <= wdata_lo;
      if (we_hi) r_count[63:32] <= wdata_hi;
    end else if (inc) begin
      // A single 64-bit add carries low into high and wraps to zero.
      r_count <= r_count + 64'd1;
    end
  end

  assign value = r_count;

endmodule : csr_counter64
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Purpose  : Machine-mode CSR register file for the RV32I core. It has two
//            write ports: CSR instructions from EX and trap sequences from
//            the CLINT. When both ports write the same address in one cycle,
//            the CLINT write wins. Reads are combinational and forward the
//            winning same-cycle write. This block also holds the mcycle and
//            minstret 64-bit counters.
// Ports    : clk, rst_n (sync, active-low)
//            ex_raddr/ex_rdata                 - EX read port (combinational)
//            ex_we/ex_waddr/ex_wdata           - EX write port
//            clint_we/clint_waddr/clint_wdata  - CLINT write port (priority)
//            inst_retire                       - minstret increment
//            csr_mtvec/csr_mepc/csr_mstatus    - registered values to CLINT
//            global_int_en                     - mstatus.MIE
// Revision : 1.0 - initial release
// ============================================================================
module csr_file
  import csr_file_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] ex_raddr,
  output logic [31:0] ex_rdata,
  input  logic        ex_we,
  input  logic [11:0] ex_waddr,
  input  logic [31:0] ex_wdata,
  input  logic        clint_we,
  input  logic [11:0] clint_waddr,
  input  logic [31:0] clint_wdata,
  input  logic        inst_retire,
  output logic [31:0] csr_mtvec,
  output logic [31:0] csr_mepc,
  output logic [31:0] csr_mstatus,
  output logic        global_int_en
);

  // --------------------------------------------------------------------------
  // Write-port decode and arbitration
  // --------------------------------------------------------------------------
  csr_sel_e    w_clint_sel;
  csr_sel_e    w_ex_sel;
  csr_sel_e    w_rd_sel;
  logic        w_ex_win;
  logic [31:0] w_clint_data;
  logic [31:0] w_ex_data;
  logic [15:0] w_clint_hot;
  logic [15:0] w_ex_hot;
  logic [15:0] w_wen;

  assign w_clint_sel  = csr_decode(clint_waddr);
  assign w_ex_sel     = csr_decode(ex_waddr);
  assign w_rd_sel     = csr_decode(ex_raddr);

  // When both ports target the same address, the EX write is dropped.
  assign w_ex_win     = ex_we && !(clint_we && (clint_waddr == ex_waddr));

  assign w_clint_data = csr_legalize(w_clint_sel, clint_wdata);
  assign w_ex_data    = csr_legalize(w_ex_sel, ex_wdata);

  // One-hot write enables, indexed by selector.
  assign w_clint_hot  = clint_we ? (16'h1 << w_clint_sel) : 16'h0;
  assign w_ex_hot     = w_ex_win ? (16'h1 << w_ex_sel)    : 16'h0;
  assign w_wen        = w_clint_hot | w_ex_hot;

  // Per-register write data, with the CLINT taking priority.
  logic [31:0] w_mstatus_d, w_mie_d, w_mtvec_d, w_mscratch_d, w_mepc_d;
  logic [31:0] w_mcause_d, w_mcycle_d, w_mcycleh_d, w_minstret_d, w_minstreth_d;

  assign w_mstatus_d   = w_clint_hot[SEL_MSTATUS]   ? w_clint_data : w_ex_data;
  assign w_mie_d       = w_clint_hot[SEL_MIE]       ? w_clint_data : w_ex_data;
  assign w_mtvec_d     = w_clint_hot[SEL_MTVEC]     ? w_clint_data : w_ex_data;
  assign w_mscratch_d  = w_clint_hot[SEL_MSCRATCH]  ? w_clint_data : w_ex_data;
  assign w_mepc_d      = w_clint_hot[SEL_MEPC]      ? w_clint_data : w_ex_data;
  assign w_mcause_d    = w_clint_hot[SEL_MCAUSE]    ? w_clint_data : w_ex_data;
  assign w_mcycle_d    = w_clint_hot[SEL_MCYCLE]    ? w_clint_data : w_ex_data;
  assign w_mcycleh_d   = w_clint_hot[SEL_MCYCLEH]   ? w_clint_data : w_ex_data;
  assign w_minstret_d  = w_clint_hot[SEL_MINSTRET]  ? w_clint_data : w_ex_data;
  assign w_minstreth_d = w_clint_hot[SEL_MINSTRETH] ? w_clint_data : w_ex_data;

  // --------------------------------------------------------------------------
  // Plain registers
  // --------------------------------------------------------------------------
  logic [31:0] r_mstatus;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mstatus  <= MSTATUS_RESET;
      r_mie      <= 32'h0;
      r_mtvec    <= 32'h0;
      r_mscratch <= 32'h0;
      r_mepc     <= 32'h0;
      r_mcause   <= 32'h0;
    end else begin
      if (w_wen[SEL_MSTATUS])  r_mstatus  <= w_mstatus_d;
      if (w_wen[SEL_MIE])      r_mie      <= w_mie_d;
      if (w_wen[SEL_MTVEC])    r_mtvec    <= w_mtvec_d;
      if (w_wen[SEL_MSCRATCH]) r_mscratch <= w_mscratch_d;
      if (w_wen[SEL_MEPC])     r_mepc     <= w_mepc_d;
      if (w_wen[SEL_MCAUSE])   r_mcause   <= w_mcause_d;
    end
  end

  // --------------------------------------------------------------------------
  // 64-bit counters
  // --------------------------------------------------------------------------
  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;

  csr_counter64 u_mcycle (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (1'b1),
    .we_lo    (w_wen[SEL_MCYCLE]),
    .wdata_lo (w_mcycle_d),
    .we_hi    (w_wen[SEL_MCYCLEH]),
    .wdata_hi (w_mcycleh_d),
    .value    (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (inst_retire),
    .we_lo    (w_wen[SEL_MINSTRET]),
    .wdata_lo (w_minstret_d),
    .we_hi    (w_wen[SEL_MINSTRETH]),
    .wdata_hi (w_minstreth_d),
    .value    (w_minstret)
  );

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  logic [31:0] w_reg_rdata;

  always_comb begin
    w_reg_rdata = 32'h0;
    case (w_rd_sel)
      SEL_MSTATUS:   w_reg_rdata = r_mstatus;
      SEL_MIE:       w_reg_rdata = r_mie;
      SEL_MTVEC:     w_reg_rdata = r_mtvec;
      SEL_MSCRATCH:  w_reg_rdata = r_mscratch;
      SEL_MEPC:      w_reg_rdata = r_mepc;
      SEL_MCAUSE:    w_reg_rdata = r_mcause;
      SEL_MCYCLE:    w_reg_rdata = w_mcycle[31:0];
      SEL_MCYCLEH:   w_reg_rdata = w_mcycle[63:32];
      SEL_MINSTRET:  w_reg_rdata = w_minstret[31:0];
      SEL_MINSTRETH: w_reg_rdata = w_minstret[63:32];
      default:       w_reg_rdata = 32'h0;
    endcase
  end

  // Forward the winning same-cycle write, after legalisation. For read-only
  // and unknown CSRs the legalised value is 0, which matches their read
  // value, so no extra qualification is needed here.
  always_comb begin
    ex_rdata = w_reg_rdata;
    if (clint_we && (clint_waddr == ex_raddr)) begin
      ex_rdata = w_clint_data;
    end else if (w_ex_win && (ex_waddr == ex_raddr)) begin
      ex_rdata = w_ex_data;
    end
  end

  // --------------------------------------------------------------------------
  // Direct outputs to the CLINT (not forwarded)
  // --------------------------------------------------------------------------
  assign csr_mtvec     = r_mtvec;
  assign csr_mepc      = r_mepc;
  assign csr_mstatus   = r_mstatus;
  assign global_int_en = r_mstatus[MSTATUS_MIE];

endmodule : csr_file
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file
// Purpose  : Directed self-checking bench for csr_file. Inputs change on the
//            falling clock edge. Outputs are sampled 1 ns later, before the
//            next rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] ex_raddr;
  logic [31:0] ex_rdata;
  logic        ex_we;
  logic [11:0] ex_waddr;
  logic [31:0] ex_wdata;
  logic        clint_we;
  logic [11:0] clint_waddr;
  logic [31:0] clint_wdata;
  logic        inst_retire;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mstatus;
  logic        global_int_en;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csr_file dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_raddr      (ex_raddr),
    .ex_rdata      (ex_rdata),
    .ex_we         (ex_we),
    .ex_waddr      (ex_waddr),
    .ex_wdata      (ex_wdata),
    .clint_we      (clint_we),
    .clint_waddr   (clint_waddr),
    .clint_wdata   (clint_wdata),
    .inst_retire   (inst_retire),
    .csr_mtvec     (csr_mtvec),
    .csr_mepc      (csr_mepc),
    .csr_mstatus   (csr_mstatus),
    .global_int_en (global_int_en)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    ex_raddr = 12'h300;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (ex_rdata !== 32'h1800) begin n_bad++; $display("FAIL rst_rdata_mstatus: got %h expected %h", ex_rdata, 32'h1800); end
    n_cmp++; if (csr_mstatus !== 32'h1800) begin n_bad++; $display("FAIL rst_mstatus: got %h expected %h", csr_mstatus, 32'h1800); end
    n_cmp++; if (csr_mtvec !== 32'h0) begin n_bad++; $display("FAIL rst_mtvec: got %h expected %h", csr_mtvec, 32'h0); end
    n_cmp++; if (csr_mepc !== 32'h0) begin n_bad++; $display("FAIL rst_mepc: got %h expected %h", csr_mepc, 32'h0); end
    n_cmp++; if (global_int_en !== 1'b0) begin n_bad++; $display("FAIL rst_gie: got %b expected %b", global_int_en, 1'b0); end
    ex_raddr = 12'hB00;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (ex_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_mcycle_first: got %h expected %h", ex_rdata, 32'h0); end
    @(negedge clk); #1;
    n_cmp++; if (ex_rdata !== 32'h1) begin n_bad++; $display("FAIL mcycle_inc: got %h expected %h", ex_rdata, 32'h1); end
  endtask

  task automatic test_mtvec();
    @(negedge clk);
    ex_we = 1'b1; ex_waddr = 12'h305; ex_wdata = 32'h0000_0103; ex_raddr = 12'h305;
    #1;
    n_cmp++; if (ex_rdata !== 32'h100) begin n_bad++; $display("FAIL mtvec_fwd: got %h expected %h", ex_rdata, 32'h100); end
    n_cmp++; if (csr_mtvec !== 32'h0) begin n_bad++; $display("FAIL mtvec_not_fwd: got %h expected %h", csr_mtvec, 32'h0); end
    @(negedge clk);
    ex_we = 1'b0;
    #1;
    n_cmp++; if (csr_mtvec !== 32'h100) begin n_bad++; $display("FAIL mtvec_reg: got %h expected %h", csr_mtvec, 32'h100); end
    n_cmp++; if (ex_rdata !== 32'h100) begin n_bad++; $display("FAIL mtvec_read: got %h expected %h", ex_rdata, 32'h100); end
  endtask

  task automatic test_trap_sequence();
    // Enable interrupts from EX first; only MIE/MPIE are writable.
    @(negedge clk);
    ex_we = 1'b1; ex_waddr = 12'h300; ex_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    ex_we = 1'b0;
    #1;
    n_cmp++; if (csr_mstatus !== 32'h1888) begin n_bad++; $display("FAIL mstatus_mask: got %h expected %h", csr_mstatus, 32'h1888); end
    n_cmp++; if (global_int_en !== 1'b1) begin n_bad++; $display("FAIL gie_set: got %b expected %b", global_int_en, 1'b1); end
    clint_we = 1'b1; clint_waddr = 12'h341; clint_wdata = 32'h84;
    @(negedge clk);
    clint_waddr = 12'h300; clint_wdata = 32'h1800; ex_raddr = 12'h341;
    #1;
    n_cmp++; if (csr_mepc !== 32'h84) begin n_bad++; $display("FAIL trap_mepc: got %h expected %h", csr_mepc, 32'h84); end
    n_cmp++; if (ex_rdata !== 32'h84) begin n_bad++; $display("FAIL trap_mepc_read: got %h expected %h", ex_rdata, 32'h84); end
    n_cmp++; if (global_int_en !== 1'b1) begin n_bad++; $display("FAIL gie_before: got %b expected %b", global_int_en, 1'b1); end
    @(negedge clk);
    clint_waddr = 12'h342; clint_wdata = 32'hB; ex_raddr = 12'h300;
    #1;
    n_cmp++; if (csr_mstatus !== 32'h1800) begin n_bad++; $display("FAIL trap_mstatus: got %h expected %h", csr_mstatus, 32'h1800); end
    n_cmp++; if (global_int_en !== 1'b0) begin n_bad++; $display("FAIL gie_cleared: got %b expected %b", global_int_en, 1'b0); end
    @(negedge clk);
    clint_we = 1'b0; ex_raddr = 12'h342;
    #1;
    n_cmp++; if (ex_rdata !== 32'hB) begin n_bad++; $display("FAIL trap_mcause: got %h expected %h", ex_rdata, 32'hB); end
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    ex_we = 1'b1; ex_waddr = 12'h341; ex_wdata = 32'h10;
    clint_we = 1'b1; clint_waddr = 12'h341; clint_wdata = 32'h20;
    ex_raddr = 12'h341;
    #1;
    n_cmp++; if (ex_rdata !== 32'h20) begin n_bad++; $display("FAIL same_fwd: got %h expected %h", ex_rdata, 32'h20); end
    @(negedge clk);
    ex_we = 1'b0;
    clint_wdata = 32'h87;
    #1;
    n_cmp++; if (csr_mepc !== 32'h20) begin n_bad++; $display("FAIL same_mepc: got %h expected %h", csr_mepc, 32'h20); end
    @(negedge clk);
    clint_we = 1'b0;
    #1;
    n_cmp++; if (csr_mepc !== 32'h84) begin n_bad++; $display("FAIL mepc_mask: got %h expected %h", csr_mepc, 32'h84); end
  endtask

  task automatic test_diff_addr();
    @(negedge clk);
    ex_we = 1'b1; ex_waddr = 12'h340; ex_wdata = 32'h55;
    clint_we = 1'b1; clint_waddr = 12'h342; clint_wdata = 32'h3;
    ex_raddr = 12'h340;
    #1;
    n_cmp++; if (ex_rdata !== 32'h55) begin n_bad++; $display("FAIL diff_fwd_ex: got %h expected %h", ex_rdata, 32'h55); end
    @(negedge clk);
    ex_we = 1'b0; clint_we = 1'b0;
    #1;
    n_cmp++; if (ex_rdata !== 32'h55) begin n_bad++; $display("FAIL diff_mscratch: got %h expected %h", ex_rdata, 32'h55); end
    ex_raddr = 12'h342;
    #1;
    n_cmp++; if (ex_rdata !== 32'h3) begin n_bad++; $display("FAIL diff_mcause: got %h expected %h", ex_rdata, 32'h3); end
  endtask

  task automatic test_misc_csrs();
    @(negedge clk);
    ex_we = 1'b1; ex_waddr = 12'h304; ex_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    ex_waddr = 12'h344; ex_wdata = 32'hFFFF_FFFF; ex_raddr = 12'h344;
    #1;
    n_cmp++; if (ex_rdata !== 32'h0) begin n_bad++; $display("FAIL mip_fwd: got %h expected %h", ex_rdata, 32'h0); end
    @(negedge clk);
    ex_waddr = 12'h7C0; ex_wdata = 32'h1234; ex_raddr = 12'h7C0;
    #1;
    n_cmp++; if (ex_rdata !== 32'h0) begin n_bad++; $display("FAIL unknown_fwd: got %h expected %h", ex_rdata, 32'h0); end
    @(negedge clk);
    ex_waddr = 12'hF14; ex_wdata = 32'h1;
    @(negedge clk);
    ex_we = 1'b0; ex_raddr = 12'h304;
    #1;
    n_cmp++; if (ex_rdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL mie_rw: got %h expected %h", ex_rdata, 32'hA5A5_A5A5); end
    ex_raddr = 12'hF14;
    #1;
    n_cmp++; if (ex_rdata !== 32'h0) begin n_bad++; $display("FAIL mhartid: got %h expected %h", ex_rdata, 32'h0); end
    ex_raddr = 12'h344;
    #1;
    n_cmp++; if (ex_rdata !== 32'h0) begin n_bad++; $display("FAIL mip_read: got %h expected %h", ex_rdata, 32'h0); end
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    ex_we = 1'b1; ex_waddr = 12'hB80; ex_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    ex_waddr = 12'hB00; ex_wdata = 32'hFFFF_FFFE;
    @(negedge clk);
    ex_we = 1'b0; ex_raddr = 12'hB00;
    #1;
    n_cmp++; if (ex_rdata !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL wrap_lo_written: got %h expected %h", ex_rdata, 32'hFFFF_FFFE); end
    ex_raddr = 12'hB80;
    #1;
    n_cmp++; if (ex_rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_hi_written: got %h expected %h", ex_rdata, 32'hFFFF_FFFF); end
    repeat (2) @(negedge clk);
    ex_raddr = 12'hB00;
    #1;
    n_cmp++; if (ex_rdata !== 32'h0) begin n_bad++; $display("FAIL wrap_lo: got %h expected %h", ex_rdata, 32'h0); end
    ex_raddr = 12'hB80;
    #1;
    n_cmp++; if (ex_rdata !== 32'h0) begin n_bad++; $display("FAIL wrap_hi: got %h expected %h", ex_rdata, 32'h0); end
  endtask

  task automatic test_minstret();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); inst_retire = 1'b1;
      @(negedge clk); inst_retire = 1'b0;
    end
    ex_raddr = 12'hB02;
    #1;
    n_cmp++; if (ex_rdata !== 32'd5) begin n_bad++; $display("FAIL minstret_count: got %h expected %h", ex_rdata, 32'd5); end
    ex_raddr = 12'hB82;
    #1;
    n_cmp++; if (ex_rdata !== 32'h0) begin n_bad++; $display("FAIL minstreth: got %h expected %h", ex_rdata, 32'h0); end
    @(negedge clk);
    ex_we = 1'b1; ex_waddr = 12'hB02; ex_wdata = 32'd100; inst_retire = 1'b1; ex_raddr = 12'hB02;
    #1;
    n_cmp++; if (ex_rdata !== 32'd100) begin n_bad++; $display("FAIL minstret_fwd: got %h expected %h", ex_rdata, 32'd100); end
    @(negedge clk);
    ex_we = 1'b0; inst_retire = 1'b0;
    #1;
    n_cmp++; if (ex_rdata !== 32'd100) begin n_bad++; $display("FAIL minstret_override: got %h expected %h", ex_rdata, 32'd100); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst_n = 1'b0;
    clint_we = 1'b1; clint_waddr = 12'h341; clint_wdata = 32'h200;
    ex_we = 1'b1; ex_waddr = 12'h300; ex_wdata = 32'h8;
    inst_retire = 1'b1;
    @(negedge clk);
    clint_we = 1'b0; ex_we = 1'b0; inst_retire = 1'b0; ex_raddr = 12'hB02;
    #1;
    n_cmp++; if (csr_mepc !== 32'h0) begin n_bad++; $display("FAIL midrst_mepc: got %h expected %h", csr_mepc, 32'h0); end
    n_cmp++; if (csr_mstatus !== 32'h1800) begin n_bad++; $display("FAIL midrst_mstatus: got %h expected %h", csr_mstatus, 32'h1800); end
    n_cmp++; if (ex_rdata !== 32'h0) begin n_bad++; $display("FAIL midrst_minstret: got %h expected %h", ex_rdata, 32'h0); end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_raddr = 12'h0; ex_we = 1'b0; ex_waddr = 12'h0; ex_wdata = 32'h0;
    clint_we = 1'b0; clint_waddr = 12'h0; clint_wdata = 32'h0;
    inst_retire = 1'b0;

    test_reset();
    test_mtvec();
    test_trap_sequence();
    test_same_addr();
    test_diff_addr();
    test_misc_csrs();
    test_counter_wrap();
    test_minstret();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_csr_file
`default_nettype wire
